// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage pattern/mask/edge trigger sequencer with per-stage counts
// Optional inter-stage timeout fallback compiled in with TRIG_SEQ_TIMEOUT_EN.
module trigger_sequencer #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4,
   parameter int CNT_W  = 8,
   parameter int TO_W   = 16,
   localparam int SW    = $clog2(STAGES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [STAGES*WIDTH-1:0]   cfg_pattern,
   input  logic [STAGES*WIDTH-1:0]   cfg_mask,
   input  logic [STAGES-1:0]         cfg_edge,
   input  logic [STAGES*CNT_W-1:0]   cfg_count,
   input  logic [SW-1:0]             cfg_last,
   input  logic [TO_W-1:0]           cfg_timeout,
   input  logic                      arm,
   input  logic                      abort,
   output logic                      armed,
   output logic [SW-1:0]             stage,
   output logic                      triggered,
   output logic                      done,
   output logic [WIDTH-1:0]          trig_data,
   output logic                      timed_out
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [SW-1:0] MAX_STAGE = SW'(STAGES - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] prev_data;
   logic [CNT_W-1:0] hit_cnt;

   logic [SW-1:0]    last_eff;
   logic [WIDTH-1:0] cur_pat;
   logic [WIDTH-1:0] cur_mask;
   logic [CNT_W-1:0] cur_cnt;
   logic [CNT_W-1:0] eff_cnt;
   logic             cur_edge;
   logic             is_match;
   logic             reached;
   logic             is_last;
   logic             run_eval;
   logic             advance;
   logic             to_hit;

   assign last_eff = (cfg_last > MAX_STAGE) ? MAX_STAGE : cfg_last;
   assign cur_pat  = cfg_pattern[int'(stage)*WIDTH +: WIDTH];
   assign cur_mask = cfg_mask[int'(stage)*WIDTH +: WIDTH];
   assign cur_cnt  = cfg_count[int'(stage)*CNT_W +: CNT_W];
   assign cur_edge = cfg_edge[stage];
   assign eff_cnt  = (cur_cnt == '0) ? CNT_W'(1) : cur_cnt;

   assign is_match = (((in_data ^ cur_pat) & cur_mask) == '0) &&
                     (!cur_edge || (in_data != prev_data));
   // >= rather than == so a count lowered mid-run still completes the stage
   assign reached  = ({1'b0, hit_cnt} + (CNT_W+1)'(1)) >= {1'b0, eff_cnt};
   assign is_last  = (stage >= last_eff);
   assign run_eval = (state == ST_RUN) && !abort && !arm;
   assign advance  = run_eval && is_match && reached;

   assign armed = (state == ST_RUN);
   assign done  = (state == ST_DONE);

`ifdef TRIG_SEQ_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
   logic            fallback;

   assign to_hit   = (cfg_timeout != '0) && (stage != '0) &&
                     (({1'b0, to_cnt} + (TO_W+1)'(1)) >= {1'b0, cfg_timeout});
   assign fallback = run_eval && !is_match && to_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt    <= '0;
         timed_out <= 1'b0;
      end else begin
         timed_out <= fallback;
         if (abort || arm || advance || fallback)
            to_cnt <= '0;
         else if ((state == ST_RUN) && (stage != '0) && (to_cnt != '1))
            to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^cfg_timeout;
   assign to_hit         = 1'b0;
   assign timed_out      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         prev_data <= '0;
         hit_cnt   <= '0;
         stage     <= '0;
         triggered <= 1'b0;
         trig_data <= '0;
      end else begin
         prev_data <= in_data;
         triggered <= 1'b0;
         if (abort) begin
            state   <= ST_IDLE;
            stage   <= '0;
            hit_cnt <= '0;
         end else if (arm) begin
            state   <= ST_RUN;
            stage   <= '0;
            hit_cnt <= '0;
         end else if (state == ST_RUN) begin
            if (is_match) begin
               if (reached) begin
                  hit_cnt <= '0;
                  if (is_last) begin
                     state     <= ST_DONE;
                     triggered <= 1'b1;
                     trig_data <= in_data;
                  end else begin
                     stage <= stage + 1'b1;
                  end
               end else begin
                  hit_cnt <= hit_cnt + 1'b1;
               end
            end else if (to_hit) begin
               stage   <= '0;
               hit_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - vector-table and scoreboard bench for trigger_sequencer
// Expectations follow the TRIG_SEQ_TIMEOUT_EN setting of the build.
module tb_trigger_sequencer;

   localparam int WIDTH  = 8;
   localparam int STAGES = 4;
   localparam int CNT_W  = 8;
   localparam int TO_W   = 16;
   localparam int SW     = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [WIDTH-1:0]        in_data;
   logic [STAGES*WIDTH-1:0] cfg_pattern;
   logic [STAGES*WIDTH-1:0] cfg_mask;
   logic [STAGES-1:0]       cfg_edge;
   logic [STAGES*CNT_W-1:0] cfg_count;
   logic [SW-1:0]           cfg_last;
   logic [TO_W-1:0]         cfg_timeout;
   logic                    arm;
   logic                    abort;
   logic                    armed;
   logic [SW-1:0]           stage;
   logic                    triggered;
   logic                    done;
   logic [WIDTH-1:0]        trig_data;
   logic                    timed_out;

   always #5 clk = ~clk;

   trigger_sequencer #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .CNT_W (CNT_W),
      .TO_W  (TO_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .cfg_pattern(cfg_pattern),
      .cfg_mask   (cfg_mask),
      .cfg_edge   (cfg_edge),
      .cfg_count  (cfg_count),
      .cfg_last   (cfg_last),
      .cfg_timeout(cfg_timeout),
      .arm        (arm),
      .abort      (abort),
      .armed      (armed),
      .stage      (stage),
      .triggered  (triggered),
      .done       (done),
      .trig_data  (trig_data),
      .timed_out  (timed_out)
   );

   typedef struct packed {
      logic       armed;
      logic [1:0] stage;
      logic       trig;
      logic       done;
      logic [7:0] tdata;
      logic       tout;
   } out_t;

   typedef struct {
      int         cfg;
      logic       rst;
      logic       arm;
      logic       abort;
      logic [7:0] din;
      out_t       exp;
   } vec_t;

   vec_t vecs[$];
   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(int c, logic r, logic a, logic ab, logic [7:0] d,
                               logic e_armed, logic [1:0] e_stage, logic e_trig,
                               logic e_done, logic [7:0] e_td, logic e_to);
      vec_t v;
      v.cfg = c; v.rst = r; v.arm = a; v.abort = ab; v.din = d;
      v.exp.armed = e_armed; v.exp.stage = e_stage; v.exp.trig = e_trig;
      v.exp.done = e_done; v.exp.tdata = e_td; v.exp.tout = e_to;
      vecs.push_back(v);
   endfunction

   task automatic apply_cfg(input int id);
      cfg_pattern = '0; cfg_mask = '0; cfg_edge = '0;
      cfg_count = '0; cfg_last = '0; cfg_timeout = '0;
      case (id)
         1: begin
            cfg_pattern[7:0] = 8'hA5; cfg_mask[7:0] = 8'hFF;
            cfg_pattern[15:8] = 8'h3C; cfg_mask[15:8] = 8'h0F;
            cfg_last = 2'd1;
         end
         2: begin
            cfg_pattern[7:0] = 8'hA5; cfg_mask[7:0] = 8'hFF;
            cfg_count[7:0] = 8'd3;
         end
         3: begin
            cfg_pattern[7:0] = 8'hA5; cfg_mask[7:0] = 8'hFF;
            cfg_edge[0] = 1'b1; cfg_count[7:0] = 8'd2;
         end
         4: begin
            cfg_pattern[7:0] = 8'hA5; cfg_mask[7:0] = 8'hFF;
            cfg_pattern[15:8] = 8'h3C; cfg_mask[15:8] = 8'hFF;
            cfg_last = 2'd1; cfg_timeout = 16'd4;
         end
         5: begin
            cfg_pattern = 32'h04030201; cfg_mask = 32'hFFFFFFFF;
            cfg_last = 2'd3;
         end
         default: ;
      endcase
   endtask

   task automatic step_and_check(input int idx);
      out_t act;
      out_t e;
      @(posedge clk);
      #1;
      act = '{armed, stage, triggered, done, trig_data, timed_out};
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL step%0d armed/stage/trig/done/tdata/tout got %b/%0d/%b/%b/%h/%b expected %b/%0d/%b/%b/%h/%b",
                  idx, act.armed, act.stage, act.trig, act.done, act.tdata, act.tout,
                  e.armed, e.stage, e.trig, e.done, e.tdata, e.tout);
      end
   endtask

   initial begin
      int first_seen;
      int pulses;

      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; in_data = '0;
      apply_cfg(0);

      // reset, reset beats arm, idle hold
      add(0,1,0,0,8'h00, 0,0,0,0,8'h00,0);
      add(0,1,1,0,8'h00, 0,0,0,0,8'h00,0);
      add(0,0,0,0,8'hA5, 0,0,0,0,8'h00,0);
      // two-stage basic sequence, masked stage 1
      add(1,0,1,0,8'h00, 1,0,0,0,8'h00,0);
      add(1,0,0,0,8'h1C, 1,0,0,0,8'h00,0);
      add(1,0,0,0,8'hA5, 1,1,0,0,8'h00,0);
      add(1,0,0,0,8'h2D, 1,1,0,0,8'h00,0);
      add(1,0,0,0,8'h1C, 0,1,1,1,8'h1C,0);
      add(1,0,0,0,8'h00, 0,1,0,1,8'h1C,0);
      add(1,0,0,0,8'hA5, 0,1,0,1,8'h1C,0);
      // count of 3 with non-consecutive hits, re-armed from DONE
      add(2,0,1,0,8'h00, 1,0,0,0,8'h1C,0);
      add(2,0,0,0,8'hA5, 1,0,0,0,8'h1C,0);
      add(2,0,0,0,8'h00, 1,0,0,0,8'h1C,0);
      add(2,0,0,0,8'h00, 1,0,0,0,8'h1C,0);
      add(2,0,0,0,8'hA5, 1,0,0,0,8'h1C,0);
      add(2,0,0,0,8'h00, 1,0,0,0,8'h1C,0);
      add(2,0,0,0,8'hA5, 0,0,1,1,8'hA5,0);
      add(2,0,0,0,8'h00, 0,0,0,1,8'hA5,0);
      // edge-qualified stage: a held value yields one hit only
      add(3,0,1,0,8'h00, 1,0,0,0,8'hA5,0);
      for (int i = 0; i < 5; i++) add(3,0,0,0,8'hA5, 1,0,0,0,8'hA5,0);
      add(3,0,0,0,8'h00, 1,0,0,0,8'hA5,0);
      add(3,0,0,0,8'hA5, 0,0,1,1,8'hA5,0);
      // inter-stage timeout, then abort beats a stage-1 match
      add(4,0,1,0,8'h00, 1,0,0,0,8'hA5,0);
      add(4,0,0,0,8'hA5, 1,1,0,0,8'hA5,0);
`ifdef TRIG_SEQ_TIMEOUT_EN
      for (int i = 0; i < 3; i++) add(4,0,0,0,8'h00, 1,1,0,0,8'hA5,0);
      add(4,0,0,0,8'h00, 1,0,0,0,8'hA5,1);
      add(4,0,0,0,8'h00, 1,0,0,0,8'hA5,0);
`else
      for (int i = 0; i < 5; i++) add(4,0,0,0,8'h00, 1,1,0,0,8'hA5,0);
`endif
      add(4,0,0,1,8'h3C, 0,0,0,0,8'hA5,0);
      // arm+abort, reset at stage 2, full four-stage run
      add(5,0,1,0,8'h00, 1,0,0,0,8'hA5,0);
      add(5,0,1,1,8'h01, 0,0,0,0,8'hA5,0);
      add(5,0,0,0,8'h01, 0,0,0,0,8'hA5,0);
      add(5,0,1,0,8'h00, 1,0,0,0,8'hA5,0);
      add(5,0,0,0,8'h01, 1,1,0,0,8'hA5,0);
      add(5,0,0,0,8'h02, 1,2,0,0,8'hA5,0);
      add(5,1,0,0,8'h03, 0,0,0,0,8'h00,0);
      add(5,0,0,0,8'h03, 0,0,0,0,8'h00,0);
      add(5,0,1,0,8'h00, 1,0,0,0,8'h00,0);
      add(5,0,0,0,8'h01, 1,1,0,0,8'h00,0);
      add(5,0,0,0,8'h02, 1,2,0,0,8'h00,0);
      add(5,0,0,0,8'h03, 1,3,0,0,8'h00,0);
      add(5,0,0,0,8'h04, 0,3,1,1,8'h04,0);
      add(5,0,0,0,8'h00, 0,3,0,1,8'h04,0);
      add(5,0,0,1,8'h00, 0,0,0,0,8'h04,0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_cfg(vecs[i].cfg);
         rst_n   = !vecs[i].rst;
         arm     = vecs[i].arm;
         abort   = vecs[i].abort;
         in_data = vecs[i].din;
         exp_q.push_back(vecs[i].exp);
         step_and_check(i);
      end

      // triggered must be a single pulse on the edge right after the completing sample
      apply_cfg(1);
      rst_n = 1'b1; abort = 1'b0;
      arm = 1'b1; in_data = 8'h00; @(posedge clk); #1;
      arm = 1'b0; in_data = 8'hA5; @(posedge clk); #1;
      in_data = 8'h1C; @(posedge clk); #1;
      first_seen = -1;
      pulses = 0;
      in_data = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (triggered) begin
            pulses++;
            if (first_seen < 0) first_seen = k;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (first_seen != 0) begin
         errors++;
         $display("FAIL trig_latency got %0d expected 0", first_seen);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL trig_pulse_width got %0d expected 1", pulses);
      end
      checks++;
      if (trig_data !== 8'h1C || done !== 1'b1) begin
         errors++;
         $display("FAIL trig_hold got tdata=%h done=%b expected tdata=1c done=1", trig_data, done);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
